// File: rtl/invert_pipe.sv
// Fixed-latency delay line with launch-time inversion, in-flight occupancy tracking and a
// saturating count of output-word transitions.
module invert_pipe #(
    parameter int unsigned      WIDTH     = 8,
    parameter int unsigned      DEPTH     = 3,
    parameter logic [WIDTH-1:0] INV_MASK  = {WIDTH{1'b1}},
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}},
    parameter int unsigned      CNT_W     = 8,
    localparam int unsigned     OCC_W     = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic             inv_en,
    input  logic             flush,
    input  logic             cnt_clr,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic [OCC_W-1:0] occupancy,
    output logic [CNT_W-1:0] toggles
);

    logic [DEPTH-1:0] stg_valid_q, stg_valid_d;
    logic [WIDTH-1:0] stg_data_q [DEPTH];
    logic [WIDTH-1:0] stg_data_d [DEPTH];
    logic [OCC_W-1:0] occ_q, occ_d;
    logic             out_valid_q;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [CNT_W-1:0] toggles_q, toggles_d;
    logic             deliver;

    always_comb begin
        stg_valid_d[0] = in_valid & ~flush;
        stg_data_d[0]  = in_data ^ (inv_en ? INV_MASK : {WIDTH{1'b0}});
        for (int k = 1; k < int'(DEPTH); k++) begin
            stg_valid_d[k] = stg_valid_q[k-1] & ~flush;
            stg_data_d[k]  = stg_data_q[k-1];
        end
    end

    always_comb begin
        occ_d = '0;
        for (int k = 0; k < int'(DEPTH); k++) begin
            occ_d = occ_d + OCC_W'(stg_valid_d[k]);
        end
    end

    // A flush also swallows the word that would have been delivered on the same edge.
    assign deliver = stg_valid_q[DEPTH-1] & ~flush;

    always_comb begin
        out_data_d = out_data_q;
        if (deliver) begin
            out_data_d = stg_data_q[DEPTH-1];
        end
        toggles_d = toggles_q;
        if (cnt_clr) begin
            toggles_d = '0;
        end else if ((out_data_d != out_data_q) && (toggles_q != {CNT_W{1'b1}})) begin
            toggles_d = toggles_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stg_valid_q <= '0;
            for (int k = 0; k < int'(DEPTH); k++) begin
                stg_data_q[k] <= '0;
            end
            occ_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= RESET_VAL;
            toggles_q   <= '0;
        end else begin
            stg_valid_q <= stg_valid_d;
            for (int k = 0; k < int'(DEPTH); k++) begin
                stg_data_q[k] <= stg_data_d[k];
            end
            occ_q       <= occ_d;
            out_valid_q <= deliver;
            out_data_q  <= out_data_d;
            toggles_q   <= toggles_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign occupancy = occ_q;
    assign toggles   = toggles_q;

endmodule

// File: tb/tb_invert_pipe.sv
// Bench for invert_pipe (WIDTH=8, DEPTH=3, CNT_W=8): directed scenarios followed by random
// traffic, checked against a launch-history model indexed by clock edge.
module tb_invert_pipe;

    localparam int NMAX = 4096;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       inv_en = 1'b0;
    logic       flush = 1'b0;
    logic       cnt_clr = 1'b0;
    logic       out_valid;
    logic [7:0] out_data;
    logic [1:0] occupancy;
    logic [7:0] toggles;

    invert_pipe dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .inv_en    (inv_en),
        .flush     (flush),
        .cnt_clr   (cnt_clr),
        .out_valid (out_valid),
        .out_data  (out_data),
        .occupancy (occupancy),
        .toggles   (toggles)
    );

    always #5 clk = ~clk;

    // Model: launch history per edge; a word launched at edge L is delivered at edge L+3
    // unless a flush or reset hits it before then.
    logic       lv [NMAX];
    logic [7:0] ld [NMAX];
    int         cyc = 0;
    logic       exp_ov = 1'b0;
    logic [7:0] exp_od = 8'h00;
    logic [1:0] exp_occ = 2'd0;
    int         exp_tg = 0;
    int         n_checks = 0;
    int         n_fail = 0;

    task automatic model_reset();
        for (int i = 0; i < NMAX; i++) lv[i] = 1'b0;
        exp_ov  = 1'b0;
        exp_od  = 8'h00;
        exp_occ = 2'd0;
        exp_tg  = 0;
    endtask

    task automatic model_edge(input logic v, input logic [7:0] d, input logic inv,
                              input logic fl, input logic clr);
        logic [7:0] new_od;
        int         cnt;
        lv[cyc] = v & ~fl;
        ld[cyc] = inv ? ~d : d;
        if (fl) begin
            for (int l = cyc - 3; l < cyc; l++) if (l >= 0) lv[l] = 1'b0;
        end
        exp_ov = (cyc >= 3) ? lv[cyc-3] : 1'b0;
        new_od = exp_ov ? ld[cyc-3] : exp_od;
        if (clr) exp_tg = 0;
        else if (new_od != exp_od && exp_tg < 255) exp_tg = exp_tg + 1;
        exp_od = new_od;
        cnt = 0;
        for (int l = cyc - 2; l <= cyc; l++) if (l >= 0 && lv[l]) cnt++;
        exp_occ = 2'(cnt);
    endtask

    task automatic check_all(input string tag);
        n_checks++;
        assert (out_valid === exp_ov) else begin
            n_fail++;
            $error("FAIL %s out_valid observed %b expected %b", tag, out_valid, exp_ov);
        end
        n_checks++;
        assert (out_data === exp_od) else begin
            n_fail++;
            $error("FAIL %s out_data observed %h expected %h", tag, out_data, exp_od);
        end
        n_checks++;
        assert (occupancy === exp_occ) else begin
            n_fail++;
            $error("FAIL %s occupancy observed %0d expected %0d", tag, occupancy, exp_occ);
        end
        n_checks++;
        assert (toggles === 8'(exp_tg)) else begin
            n_fail++;
            $error("FAIL %s toggles observed %0d expected %0d", tag, toggles, exp_tg);
        end
    endtask

    task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic step(input string tag, input logic v, input logic [7:0] d, input logic inv,
                        input logic fl, input logic clr);
        in_valid = v;
        in_data  = d;
        inv_en   = inv;
        flush    = fl;
        cnt_clr  = clr;
        @(posedge clk);
        cyc++;
        model_edge(v, d, inv, fl, clr);
        #1;
        check_all(tag);
    endtask

    task automatic idle(input string tag, input int n);
        for (int i = 0; i < n; i++) step(tag, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        model_reset();
        #3;
        check_all("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Single inverted word: 3C -> C3 after three cycles.
        step("single_launch", 1'b1, 8'h3C, 1'b1, 1'b0, 1'b0);
        idle("single_wait", 2);
        check8("single_not_yet", {7'd0, out_valid}, 8'h00);
        idle("single_out", 1);
        check8("single_data", out_data, 8'hC3);
        check8("single_valid", {7'd0, out_valid}, 8'h01);
        check8("single_toggles", toggles, 8'h01);
        check8("single_occ", {6'd0, occupancy}, 8'h00);

        // Streaming without inversion.
        step("stream_1", 1'b1, 8'h01, 1'b0, 1'b0, 1'b0);
        step("stream_2", 1'b1, 8'h02, 1'b0, 1'b0, 1'b0);
        step("stream_3", 1'b1, 8'h03, 1'b0, 1'b0, 1'b0);
        check8("stream_occ_peak", {6'd0, occupancy}, 8'h03);
        idle("stream_drain", 3);
        check8("stream_last", out_data, 8'h03);
        check8("stream_toggles", toggles, 8'h04);

        // Bubbles between two identical words.
        step("bubble_1", 1'b1, 8'hAA, 1'b0, 1'b0, 1'b0);
        idle("bubble_gap", 2);
        step("bubble_2", 1'b1, 8'hAA, 1'b0, 1'b0, 1'b0);
        idle("bubble_drain", 3);
        check8("bubble_data", out_data, 8'hAA);
        check8("bubble_toggles", toggles, 8'h05);

        // Flush with three words in flight and a same-cycle launch.
        step("flush_w1", 1'b1, 8'h11, 1'b0, 1'b0, 1'b0);
        step("flush_w2", 1'b1, 8'h22, 1'b0, 1'b0, 1'b0);
        step("flush_w3", 1'b1, 8'h33, 1'b0, 1'b0, 1'b0);
        step("flush_edge", 1'b1, 8'h44, 1'b0, 1'b1, 1'b0);
        check8("flush_occ", {6'd0, occupancy}, 8'h00);
        idle("flush_after", 3);
        check8("flush_hold", out_data, 8'hAA);

        // Saturation: 260 alternating words push the counter past 255.
        step("sat_clear", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 260; i++) begin
            step("sat_stream", 1'b1, (i % 2 == 0) ? 8'h00 : 8'hFF, 1'b0, 1'b0, 1'b0);
        end
        idle("sat_drain", 3);
        check8("sat_value", toggles, 8'hFF);
        // cnt_clr on the edge of a changing delivery wins over the increment.
        step("clr_launch", 1'b1, 8'h5A, 1'b0, 1'b0, 1'b0);
        idle("clr_wait", 2);
        step("clr_edge", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        check8("clr_prio", toggles, 8'h00);
        check8("clr_data", out_data, 8'h5A);

        // Async reset with two words in flight.
        step("arst_w1", 1'b1, 8'h77, 1'b0, 1'b0, 1'b0);
        step("arst_w2", 1'b1, 8'h88, 1'b1, 1'b0, 1'b0);
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_all("arst_immediate");
        #1;
        rst = 1'b0;
        idle("arst_after", 4);
        step("arst_new", 1'b1, 8'h0F, 1'b1, 1'b0, 1'b0);
        idle("arst_new_out", 3);
        check8("arst_new_data", out_data, 8'hF0);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            step("random", 1'($urandom_range(0, 3) != 0), 8'($urandom),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 15) == 0),
                 1'($urandom_range(0, 31) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/invert_pipe.md
Name: invert_pipe

Overview:
- Parametrised, clocked successor to the single-bit transport-delay inverter.
- Passes a WIDTH-bit word through a DEPTH-stage delay line, applying a per-bit inversion mask when enabled at entry.
- Tracks valid words in flight and counts output transitions so benches can compare digital activity against the analog side of mixed-mode runs.
- Sits between digital stimulus and AD/DA boundary nodes in gnucap mixed-signal test circuits.

Parameters:
- WIDTH, 8, data word width in bits (>=1).
- DEPTH, 3, delay-line length in clock cycles (>=1).
- INV_MASK, {WIDTH{1'b1}}, bits inverted when inv_en=1.
- RESET_VAL, {WIDTH{1'b0}}, out_data value after reset.
- CNT_W, 8, width of the transition counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  in_data is a word to launch this cycle.
- in_data  input  WIDTH  input word.
- inv_en  input  1  apply INV_MASK to the word launched this cycle.
- flush  input  1  discard all words in flight.
- cnt_clr  input  1  clear the transition counter.
- out_valid  output  1  out_data updated this cycle with a delivered word.
- out_data  output  WIDTH  last delivered word (registered, held between deliveries).
- occupancy  output  $clog2(DEPTH+1)  number of valid stages in flight.
- toggles  output  CNT_W  saturating count of cycles in which out_data changed.

Behaviour:
- Reset (async, rst=1): all stage valid/data = 0, out_valid=0, out_data=RESET_VAL, occupancy=0, toggles=0. Reset mid-stream drops all words. No out_valid until a new word has traversed the full DEPTH.
- Stage 0 captures at every clk edge:
  - valid <= in_valid & ~flush
  - data <= in_data ^ (inv_en ? INV_MASK : 0)
- Stage k captures stage k-1 every cycle. There is no stall and no backpressure.
- Latency: a word with in_valid=1 at edge N appears with out_valid=1 at edge N+DEPTH. out_valid is the last-stage valid.
- out_data loads last-stage data only when the last-stage valid=1. Otherwise it holds its value.
- Inversion is decided at launch. Toggling inv_en while words are in flight does not affect them.
- Bubbles (in_valid=0) propagate as invalid stages. out_data holds across them.
- Flush: at the edge where flush=1, all stage valid bits clear (data don't-care) and the same-cycle input is discarded. out_data keeps its value. The next cycle has occupancy=0 and out_valid=0.
- occupancy = popcount of stage valid bits, registered together with the stages. Range 0..DEPTH.
- toggles increments by 1 at an edge where out_data's new value differs from its old value (any bit). It saturates at 2^CNT_W-1 and does not wrap.
  - cnt_clr=1 sets toggles to 0 and takes priority over a same-edge increment.
  - cnt_clr does not touch the data path.
- flush and cnt_clr together: both take effect independently.
- DEPTH=1: single stage, latency 1 cycle. occupancy is 1 bit.

Test Plan:
- Reset then single word (WIDTH=8, DEPTH=3, inv_en=1): in_data=8'h3C at edge 1 -> out_valid=1 and out_data=8'hC3 at edge 4. occupancy goes 1,1,1 then 0. toggles=1.
- Streaming, inv_en=0: 8'h01,8'h02,8'h03 on consecutive edges -> same values out on edges 4,5,6. occupancy peaks at 3. toggles=3.
- Bubbles and hold: word 8'hAA, two idle cycles, word 8'hAA (inv_en=0) -> out_data stays 8'hAA throughout. Second delivery does not increment toggles (value unchanged).
- Flush mid-stream: three words in flight, flush=1 with in_valid=1 -> no out_valid for the next 3 cycles, occupancy=0, out_data unchanged.
- Counter saturation (CNT_W=2): alternate 8'h00/8'hFF for 6 words -> toggles stops at 3. cnt_clr together with a changing delivery -> toggles=0.
- Async reset mid-operation: assert rst between edges with 2 words in flight -> outputs immediately at reset values. After release, no out_valid until a new word has waited 3 cycles.
